// File: rtl/fnd_scan_capture_pkg.sv
// Shared constants and helpers for the seven-segment scan capture block.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package fnd_scan_capture_pkg;

  localparam int unsigned DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] NUM_BLANK = 4'hE;
  localparam logic [3:0] NUM_BAD   = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } scan_state_t;

  // True when exactly one active-low enable is asserted.
  function automatic logic enb_one_low(input logic [DIGITS-1:0] enb);
    int unsigned zeros;
    zeros = 0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (!enb[k]) zeros++;
    end
    return (zeros == 1);
  endfunction

  function automatic logic [2:0] enb_index(input logic [DIGITS-1:0] enb);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (!enb[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fnd_scan_capture_enc.sv
// Combinational seven-segment pattern to digit decoder (inverse of fnd_dec).
// Blank maps to NUM_BLANK, any unrecognised pattern to NUM_BAD.
module fnd_enc
  import fnd_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] num
);

  always_comb begin
    case (seg)
      SEG_0:     num = 4'h0;
      SEG_1:     num = 4'h1;
      SEG_2:     num = 4'h2;
      SEG_3:     num = 4'h3;
      SEG_4:     num = 4'h4;
      SEG_5:     num = 4'h5;
      SEG_6:     num = 4'h6;
      SEG_7:     num = 4'h7;
      SEG_8:     num = 4'h8;
      SEG_9:     num = 4'h9;
      SEG_BLANK: num = NUM_BLANK;
      default:   num = NUM_BAD;
    endcase
  end

endmodule

// File: rtl/fnd_scan_capture.sv
// Samples a multiplexed six-digit seven-segment bus and rebuilds the full
// display image, decoded digits, frame strobe, scan-error and stall flags.
module fnd_scan_capture
  import fnd_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [41:0] o_six_digit_seg,
  output logic [5:0]  o_six_dp,
  output logic [23:0] o_six_num,
  output logic        o_frame_valid,
  output logic        o_err,
  output logic        o_stall
);

  localparam int unsigned CW = $clog2(SETTLE);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX    = IW'(TIMEOUT);

  logic [13:0]       sync1, sync2, prev;
  logic [6:0]        s_seg;
  logic              s_dp;
  logic [DIGITS-1:0] s_enb;
  logic              change, enb_change;

  scan_state_t       state, state_next;
  logic [CW-1:0]     settle_cnt;
  logic              term, enb_single, enb_idle;
  logic              cnt_clr, cnt_inc, latch, bad_enb, capture;

  logic [2:0]        cap_idx;
  logic [6:0]        cap_seg;
  logic              cap_dp;
  logic [6:0]        shadow [DIGITS];
  logic [DIGITS-1:0] shadow_dp;
  logic [DIGITS-1:0] mask, mask_next;
  logic              publish, repeat_hit;
  logic [3:0]        enc_num [DIGITS];

  logic [IW-1:0]     idle_cnt;
  logic              stall_hit;

  // Reset to all ones so the bus looks idle (no digit enabled) until real data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {i_seg_enb, i_seg_dp, i_seg};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign s_seg      = sync2[6:0];
  assign s_dp       = sync2[7];
  assign s_enb      = sync2[13:8];
  assign change     = (sync2 != prev);
  assign enb_change = (sync2[13:8] != prev[13:8]);

  assign term       = (settle_cnt == SETTLE_LAST);
  assign enb_single = enb_one_low(s_enb);
  assign enb_idle   = &s_enb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT:    state_next = ST_SETTLE;
      ST_SETTLE:  if (!change && term) state_next = enb_single ? ST_CAPTURE : ST_HOLD;
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD:    if (change) state_next = ST_SETTLE;
      default:    state_next = ST_WAIT;
    endcase
  end

  // A change on the terminal-count cycle wins: counter restarts, nothing is evaluated.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    latch   = 1'b0;
    bad_enb = 1'b0;
    capture = 1'b0;
    case (state)
      ST_WAIT:    cnt_clr = 1'b1;
      ST_SETTLE: begin
        if (change) begin
          cnt_clr = 1'b1;
        end else if (term) begin
          latch   = enb_single;
          bad_enb = !enb_single && !enb_idle;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_CAPTURE: capture = 1'b1;
      ST_HOLD:    cnt_clr = change;
      default:    cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (cnt_clr) begin
      settle_cnt <= '0;
    end else if (cnt_inc) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Capture data is frozen at evaluation so a change during CAPTURE cannot corrupt it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_idx <= '0;
      cap_seg <= '0;
      cap_dp  <= 1'b0;
    end else if (latch) begin
      cap_idx <= enb_index(s_enb);
      cap_seg <= s_seg;
      cap_dp  <= s_dp;
    end
  end

  assign stall_hit = !enb_change && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      o_stall  <= 1'b0;
    end else if (enb_change) begin
      idle_cnt <= '0;
      o_stall  <= 1'b0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (stall_hit) o_stall <= 1'b1;
    end
  end

  assign publish    = &mask;
  assign repeat_hit = capture && mask[cap_idx] && !publish;

  always_comb begin
    mask_next = publish ? '0 : mask;
    if (capture) mask_next[cap_idx] = 1'b1;
    if (stall_hit) mask_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask      <= '0;
      shadow_dp <= '0;
      for (int unsigned k = 0; k < DIGITS; k++) shadow[k] <= '0;
    end else begin
      mask <= mask_next;
      if (capture) begin
        shadow[cap_idx]    <= cap_seg;
        shadow_dp[cap_idx] <= cap_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_err <= 1'b0;
    else if (bad_enb || repeat_hit) o_err <= 1'b1;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    fnd_enc u_enc (
      .seg (shadow[g]),
      .num (enc_num[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_six_digit_seg <= '0;
      o_six_dp        <= '0;
      o_six_num       <= {DIGITS{NUM_BLANK}};
      o_frame_valid   <= 1'b0;
    end else begin
      o_frame_valid <= publish;
      if (publish) begin
        o_six_dp <= shadow_dp;
        for (int unsigned k = 0; k < DIGITS; k++) begin
          o_six_digit_seg[7*k +: 7] <= shadow[k];
          o_six_num[4*k +: 4]       <= enc_num[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_capture.sv
// Directed/randomised scan stimulus checked against a frame-level model of the
// display monitor: digits captured per dwell, frames published when all six seen.
module tb_fnd_scan_capture;

  localparam int unsigned SETTLE  = 16;
  localparam int unsigned TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  enb;
  logic [41:0] o_six_digit_seg;
  logic [5:0]  o_six_dp;
  logic [23:0] o_six_num;
  logic        o_frame_valid, o_err, o_stall;

  fnd_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_seg           (seg),
    .i_seg_dp        (dp),
    .i_seg_enb       (enb),
    .o_six_digit_seg (o_six_digit_seg),
    .o_six_dp        (o_six_dp),
    .o_six_num       (o_six_num),
    .o_frame_valid   (o_frame_valid),
    .o_err           (o_err),
    .o_stall         (o_stall)
  );

  always #10 clk = ~clk;

  int unsigned n_vec = 0, n_bad = 0, pub_cnt = 0;

  always @(negedge clk) if (o_frame_valid) pub_cnt++;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  logic [6:0]  m_shadow [6];
  logic [5:0]  m_shadow_dp, m_mask, m_dpo;
  logic        m_err, m_stall;
  int unsigned m_pub;
  logic [41:0] m_seg;
  logic [23:0] m_num;

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    if (s == 7'd0) return 4'hE;
    for (int i = 0; i < 10; i++) if (pat[i] == s) return 4'(i);
    return 4'hF;
  endfunction

  function automatic logic [6:0] rnd_seg();
    case ($urandom % 4)
      0:       return 7'd0;
      3:       return 7'($urandom);
      default: return pat[$urandom % 10];
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = '0; m_shadow_dp = '0; m_err = 1'b0; m_stall = 1'b0;
    m_seg = '0; m_dpo = '0; m_num = 24'hEEEEEE;
    for (int i = 0; i < 6; i++) m_shadow[i] = '0;
  endtask

  task automatic model_capture(input int unsigned k, input logic [6:0] s, input logic d);
    if (m_mask[k]) m_err = 1'b1;
    m_shadow[k] = s;
    m_shadow_dp[k] = d;
    m_mask[k] = 1'b1;
    if (m_mask == 6'h3F) begin
      m_pub++;
      for (int i = 0; i < 6; i++) begin
        m_seg[7*i +: 7] = m_shadow[i];
        m_num[4*i +: 4] = ref_decode(m_shadow[i]);
      end
      m_dpo  = m_shadow_dp;
      m_mask = '0;
    end
  endtask

  task automatic check_all();
    chk("err",   64'(o_err), 64'(m_err));
    chk("stall", 64'(o_stall), 64'(m_stall));
    chk("pubs",  64'(pub_cnt), 64'(m_pub));
    chk("seg",   64'(o_six_digit_seg), 64'(m_seg));
    chk("dp",    64'(o_six_dp), 64'(m_dpo));
    chk("num",   64'(o_six_num), 64'(m_num));
  endtask

  // Show digit k; a dwell well past TIMEOUT freezes the enables and stalls.
  task automatic show(input int unsigned k, input logic [6:0] s, input logic d,
                      input int unsigned dwell, input bit glitch);
    enb = ~(6'b1 << k);
    dp  = d;
    if (glitch) begin
      for (int i = 0; i < 5; i++) begin
        seg = 7'($urandom);
        @(negedge clk);
      end
    end
    seg = s;
    repeat (dwell) @(negedge clk);
    model_capture(k, s, d);
    m_stall = (dwell > TIMEOUT + 20);
    if (m_stall) m_mask = '0;
  endtask

  task automatic do_reset();
    enb = 6'h3F; seg = '0; dp = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 64'(o_frame_valid), 64'd0);
    check_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [6:0] clean [6];
    clean = '{7'b0110000, 7'b1011011, 7'd0, 7'd0, 7'd0, 7'd0};
    m_pub = 0;
    model_reset();
    rst_n = 1'b0; enb = 6'h3F; seg = '0; dp = 1'b0;
    #25;
    chk("rst_seg",   64'(o_six_digit_seg), 64'd0);
    chk("rst_num",   64'(o_six_num), 64'hEEEEEE);
    chk("rst_valid", 64'(o_frame_valid), 64'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean scan: two identical frames.
    for (int f = 0; f < 2; f++) begin
      for (int unsigned k = 0; k < 6; k++) show(k, clean[k], 1'b0, 150, 1'b0);
      check_all();
      chk("clean_num", 64'(o_six_num), 64'hEEEE51);
      chk("clean_lo",  64'(o_six_digit_seg[13:0]), 64'(14'b1011011_0110000));
    end

    // Random frames, some digits starting with a segment glitch burst.
    for (int f = 0; f < 4; f++) begin
      for (int unsigned k = 0; k < 6; k++) begin
        show(k, rnd_seg(), 1'($urandom), 30 + $urandom % 90, 1'($urandom));
        check_all();
      end
    end

    // Repeated digit within a frame.
    show(0, pat[4], 1'b0, 60, 1'b0);
    show(1, pat[3], 1'b1, 60, 1'b0);
    show(1, pat[7], 1'b0, 60, 1'b0);
    for (int unsigned k = 2; k < 6; k++) show(k, rnd_seg(), 1'($urandom), 60, 1'b0);
    check_all();
    chk("rep_err", 64'(o_err), 64'd1);
    chk("rep_d1",  64'(o_six_digit_seg[13:7]), 64'(7'b1110000));

    do_reset();

    // Bad enable pattern, then a clean frame still publishes.
    enb = 6'b111100; seg = pat[2]; dp = 1'b0;
    repeat (100) @(negedge clk);
    m_err = 1'b1;
    check_all();
    for (int unsigned k = 0; k < 6; k++) show(k, rnd_seg(), 1'($urandom), 50, 1'b0);
    check_all();

    // Stall on digit 2: partial frame discarded, scan resumes.
    show(0, pat[1], 1'b0, 50, 1'b0);
    show(1, pat[2], 1'b0, 50, 1'b0);
    show(2, pat[3], 1'b1, 300, 1'b0);
    check_all();
    for (int unsigned k = 3; k < 6; k++) begin
      show(k, rnd_seg(), 1'($urandom), 50, 1'b0);
      check_all();
    end
    for (int unsigned k = 0; k < 6; k++) show(k, rnd_seg(), 1'($urandom), 50, 1'b0);
    check_all();

    // Reset mid-frame, then six fresh digits are needed for a publish.
    for (int unsigned k = 0; k < 4; k++) show(k, rnd_seg(), 1'($urandom), 50, 1'b0);
    do_reset();
    for (int unsigned k = 0; k < 5; k++) begin
      show(k, rnd_seg(), 1'($urandom), 50, 1'b0);
      check_all();
    end
    show(5, pat[9], 1'b1, 50, 1'b0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
